reg_dump_controller: RTL and testbench

REG_DUMP_CONTROLLER -- requirements
Module: reg_dump_controller

---
 rtl/reg_dump_controller_pkg.sv | 21 ++
 rtl/reg_dump_controller_byte_serializer.sv | 37 +++
 rtl/reg_dump_controller.sv | 117 +++++++++++
 tb/tb_reg_dump_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_controller_pkg.sv
// Shared definitions for the register-dump path: FSM encoding, frame header
// and byte extraction helper, reused by the UART and top-level blocks.
package reg_dump_controller_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_HDR  = 3'd1;
  localparam state_t ST_SEL  = 3'd2;
  localparam state_t ST_SEND = 3'd3;
  localparam state_t ST_CSUM = 3'd4;
  localparam state_t ST_FIN  = 3'd5;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  // Little-endian byte lane select: idx 0 is word[7:0].
  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/reg_dump_controller_byte_serializer.sv
// Splits a 32-bit word into four bytes, LSB first, under a valid/ready handshake.
module byte_serializer
  import reg_dump_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] word_in,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last
);

  logic [31:0] word;
  logic [1:0]  idx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      word      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      word      <= word_in;
      idx       <= '0;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      idx <= idx + 2'd1;
      if (idx == 2'd3) out_valid <= 1'b0;
    end
  end

  assign out_data = byte_of(word, idx);
  assign out_last = (idx == 2'd3);

endmodule

// File: rtl/reg_dump_controller.sv
// Halts the CPU and streams the register file over UART as
// header, 4*NUM_REGS little-endian data bytes and an XOR checksum.
module reg_dump_controller
  import reg_dump_controller_pkg::*;
#(
  parameter int         NUM_REGS = 32,
  parameter logic [7:0] HEADER   = DEFAULT_HEADER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] Debug_out,
  output logic [4:0]  Debug_Source_select,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cpu_halt,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_SEL = 5'(NUM_REGS - 1);

  state_t     state;
  logic [7:0] ctl_data;
  logic       ctl_valid;
  logic [7:0] checksum;

  logic       ser_load;
  logic [7:0] ser_data;
  logic       ser_valid;
  logic       ser_last;
  logic       ser_accept;

  assign ser_load   = (state == ST_SEL);
  assign ser_accept = ser_valid && tx_ready;

  byte_serializer u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (ser_load),
    .word_in  (Debug_out),
    .out_ready(tx_ready),
    .out_data (ser_data),
    .out_valid(ser_valid),
    .out_last (ser_last)
  );

  // Header/checksum come from ctl_*, data bytes from the serializer; never both valid.
  assign tx_valid = ctl_valid || ser_valid;
  assign tx_data  = ser_valid ? ser_data : ctl_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= ST_IDLE;
      ctl_data            <= '0;
      ctl_valid           <= 1'b0;
      Debug_Source_select <= '0;
      busy                <= 1'b0;
      cpu_halt            <= 1'b0;
      done                <= 1'b0;
      checksum            <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_HDR;
            ctl_data  <= HEADER;
            ctl_valid <= 1'b1;
            busy      <= 1'b1;
            cpu_halt  <= 1'b1;
            checksum  <= '0;
          end
        end
        ST_HDR: begin
          if (ctl_valid && tx_ready) begin
            state               <= ST_SEL;
            ctl_valid           <= 1'b0;
            Debug_Source_select <= '0;
          end
        end
        ST_SEL: state <= ST_SEND;
        ST_SEND: begin
          if (ser_accept) begin
            checksum <= checksum ^ ser_data;
            if (ser_last) begin
              if (Debug_Source_select < LAST_SEL) begin
                Debug_Source_select <= Debug_Source_select + 5'd1;
                state               <= ST_SEL;
              end else begin
                // Fold the final data byte in here so the checksum byte is ready next cycle.
                state     <= ST_CSUM;
                ctl_data  <= checksum ^ ser_data;
                ctl_valid <= 1'b1;
              end
            end
          end
        end
        ST_CSUM: begin
          if (ctl_valid && tx_ready) begin
            state     <= ST_FIN;
            ctl_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
        ST_FIN: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          cpu_halt <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_controller.sv
// Directed bench: default 32-register dump and a 2-register instance, each
// fed from a bench-owned register file, with a negedge byte monitor.
module tb_reg_dump_controller;

  logic        clk;
  logic        reset;

  logic        start_a, tx_ready_a, tx_valid_a, halt_a, busy_a, done_a;
  logic [31:0] dbg_out_a;
  logic [4:0]  sel_a;
  logic [7:0]  tx_data_a;

  logic        start_b, tx_ready_b, tx_valid_b, halt_b, busy_b, done_b;
  logic [31:0] dbg_out_b;
  logic [4:0]  sel_b;
  logic [7:0]  tx_data_b;

  logic [31:0] rf_a [32];
  logic [31:0] rf_b [32];

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] ref_q[$];
  int done_cnt_a = 0, done_cnt_b = 0;
  int hold_err_a = 0, stall_cnt_a = 0;
  int halt_err_a = 0, halt_err_b = 0, done2_err = 0;
  int sel_err_b = 0;
  int idle_run_a = 0, last_idle_run_a = 0;
  logic [4:0] sel_max_b = '0;
  logic hold_pending_a = 1'b0;
  logic [7:0] held_a = '0;
  logic done_prev_a = 1'b0, done_prev_b = 1'b0;
  int ready_mode_a = 0;
  int ready_cyc = 0;

  reg_dump_controller u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .Debug_out(dbg_out_a),
    .Debug_Source_select(sel_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .cpu_halt(halt_a), .busy(busy_a), .done(done_a)
  );

  reg_dump_controller #(.NUM_REGS(2)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .Debug_out(dbg_out_b),
    .Debug_Source_select(sel_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .cpu_halt(halt_b), .busy(busy_b), .done(done_b)
  );

  assign dbg_out_a = rf_a[sel_a];
  assign dbg_out_b = rf_b[sel_b];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_a[i] = 32'h0;
      rf_b[i] = 32'h0;
    end
    rf_a[1] = 32'h11223344;
    rf_b[1] = 32'hDEADBEEF;
  end

  // tx_ready driver for instance A: tied high, or high one cycle in three.
  initial begin
    tx_ready_a = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_cyc++;
      tx_ready_a = (ready_mode_a == 0) ? 1'b1 : (ready_cyc % 3 == 0);
    end
  end

  // Monitor at negedge: everything here is what the next rising edge will see.
  always @(negedge clk) begin
    if (tx_valid_a && tx_ready_a && !reset) q_a.push_back(tx_data_a);
    if (tx_valid_b && tx_ready_b && !reset) q_b.push_back(tx_data_b);
    if (hold_pending_a && tx_valid_a && !reset && tx_data_a !== held_a) hold_err_a++;
    hold_pending_a = tx_valid_a && !tx_ready_a && !reset;
    held_a         = tx_data_a;
    if (tx_valid_a && !tx_ready_a) stall_cnt_a++;
    if (halt_a !== busy_a) halt_err_a++;
    if (halt_b !== busy_b) halt_err_b++;
    if (done_a && done_prev_a) done2_err++;
    if (done_b && done_prev_b) done2_err++;
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    done_prev_a = done_a;
    done_prev_b = done_b;
    if (sel_b > 5'd1) sel_err_b++;
    if (sel_b > sel_max_b) sel_max_b = sel_b;
    if (!busy_a) idle_run_a++;
    else begin
      if (idle_run_a != 0) last_idle_run_a = idle_run_a;
      idle_run_a = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input bit use_b, input int budget, input string tag);
    int n;
    n = 0;
    while (((use_b ? done_b : done_a) !== 1'b1) && n < budget) begin
      step(1);
      n++;
    end
    check({tag, " done seen"}, {31'b0, (use_b ? done_b : done_a)}, 32'd1);
  endtask

  task automatic clear_a();
    q_a.delete();
    done_cnt_a = 0;
  endtask

  // Default-preload frame: A5, reg0 zeros, 44 33 22 11, zeros, checksum 44.
  task automatic check_default_frame(input string tag, input int base);
    int mism;
    logic [7:0] exp;
    mism = 0;
    for (int i = 1; i <= 128; i++) begin
      case (i)
        5:       exp = 8'h44;
        6:       exp = 8'h33;
        7:       exp = 8'h22;
        8:       exp = 8'h11;
        default: exp = 8'h00;
      endcase
      if (q_a[base + i] !== exp) mism++;
    end
    check({tag, " header"}, {24'b0, q_a[base]}, 32'hA5);
    check({tag, " x1 low byte"}, {24'b0, q_a[base + 5]}, 32'h44);
    check({tag, " data bytes"}, mism, 0);
    check({tag, " checksum"}, {24'b0, q_a[base + 129]}, 32'h44);
  endtask

  initial begin
    int n;
    int mism;
    logic [7:0] exp_b [10];

    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    tx_ready_b = 1'b1;
    step(3);
    check("reset tx_valid", {31'b0, tx_valid_a}, 0);
    check("reset tx_data", {24'b0, tx_data_a}, 0);
    check("reset select", {27'b0, sel_a}, 0);
    check("reset busy", {31'b0, busy_a}, 0);
    check("reset cpu_halt", {31'b0, halt_a}, 0);
    check("reset done", {31'b0, done_a}, 0);
    reset = 1'b0;
    step(2);

    // Single dump, tx_ready tied high.
    clear_a();
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    check("hdr tx_data", {24'b0, tx_data_a}, 32'hA5);
    check("hdr tx_valid", {31'b0, tx_valid_a}, 1);
    check("hdr busy", {31'b0, busy_a}, 1);
    check("hdr cpu_halt", {31'b0, halt_a}, 1);
    wait_done(1'b0, 400, "f1");
    step(2);
    check("f1 length", q_a.size(), 130);
    check_default_frame("f1", 0);
    check("f1 done pulses", done_cnt_a, 1);
    check("f1 idle busy", {31'b0, busy_a}, 0);
    ref_q = q_a;

    // Throttled dump with a stray start mid-frame.
    ready_mode_a = 1;
    clear_a();
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    step(40);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    wait_done(1'b0, 1500, "f2");
    step(2);
    ready_mode_a = 0;
    check("f2 length", q_a.size(), 130);
    mism = 0;
    for (int i = 0; i < 130; i++) if (q_a[i] !== ref_q[i]) mism++;
    check("f2 stream vs f1", mism, 0);
    check("f2 tx_data held", hold_err_a, 0);
    check("f2 stalls seen", {31'b0, (stall_cnt_a > 0)}, 1);
    check("f2 done pulses", done_cnt_a, 1);

    // start held high: two back-to-back frames, one IDLE cycle between.
    clear_a();
    start_a = 1'b1;
    step(300);
    start_a = 1'b0;
    wait_done(1'b0, 200, "held");
    step(5);
    check("held done pulses", done_cnt_a, 2);
    check("held length", q_a.size(), 260);
    check("held idle gap", last_idle_run_a, 1);
    check("held second header", {24'b0, q_a[130]}, 32'hA5);
    check("held ends idle", {31'b0, busy_a}, 0);

    // Reset after 50 accepted bytes abandons the frame.
    clear_a();
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    n = 0;
    while (q_a.size() < 50 && n < 500) begin
      step(1);
      n++;
    end
    check("mid bytes before reset", q_a.size(), 50);
    reset = 1'b1;
    step(1);
    check("mid reset tx_valid", {31'b0, tx_valid_a}, 0);
    check("mid reset busy", {31'b0, busy_a}, 0);
    check("mid reset cpu_halt", {31'b0, halt_a}, 0);
    check("mid reset select", {27'b0, sel_a}, 0);
    reset = 1'b0;
    step(3);
    check("mid no trailing byte", q_a.size(), 50);
    clear_a();
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    wait_done(1'b0, 400, "fresh");
    step(2);
    check("fresh length", q_a.size(), 130);
    check_default_frame("fresh", 0);

    // NUM_REGS=2 instance.
    exp_b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    q_b.delete();
    done_cnt_b = 0;
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    wait_done(1'b1, 100, "n2");
    step(2);
    check("n2 length", q_b.size(), 10);
    mism = 0;
    for (int i = 0; i < 10; i++) if (q_b[i] !== exp_b[i]) mism++;
    check("n2 frame bytes", mism, 0);
    check("n2 checksum", {24'b0, q_b[9]}, 32'h22);
    check("n2 select bound", sel_err_b, 0);
    check("n2 select max", {27'b0, sel_max_b}, 1);
    check("n2 done pulses", done_cnt_b, 1);

    check("cpu_halt==busy a", halt_err_a, 0);
    check("cpu_halt==busy b", halt_err_b, 0);
    check("done single cycle", done2_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
